// File: rtl/pcie_tlp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pcie_tlp_pkg
//  Purpose  : Shared widths, FIFO word layout, TLP type encodings and the
//             TLP byte-length helper for the PCIe RX capture path.
//  Revision : 1.0  initial release
// ============================================================================
package pcie_tlp_pkg;

  localparam int TLP_LEN        = 11;   // byte-length field, holds up to 2047
  localparam int TLP_TAG        = 8;
  localparam int RX_USER        = 22;
  localparam int PCIE_FIFO64_RX = 1 + 1 + 8 + 64 + RX_USER + TLP_LEN + TLP_TAG;

  // Type field encodings (DW0[28:24])
  localparam logic [3:0] TYPE_MEM_HI = 4'b0000;   // MRd/MWr/MRdLk: 0000x
  localparam logic [4:0] TYPE_CPL    = 5'b01010;  // Cpl/CplD

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BODY  = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  // One FIFO word, MSB first: {tvalid, tlast, tkeep, tdata, tuser, tlp_len, tlp_tag}
  typedef struct packed {
    logic                tvalid;
    logic                tlast;
    logic [7:0]          tkeep;
    logic [63:0]         tdata;
    logic [RX_USER-1:0]  tuser;
    logic [TLP_LEN-1:0]  tlp_len;
    logic [TLP_TAG-1:0]  tlp_tag;
  } fifo_word_t;

  // One-beat hold register contents
  typedef struct packed {
    logic [63:0]         tdata;
    logic [7:0]          tkeep;
    logic [RX_USER-1:0]  tuser;
    logic                last;
    logic [TLP_LEN-1:0]  tlp_len;
    logic [TLP_TAG-1:0]  tlp_tag;
  } hold_t;

  // Total TLP bytes from DW0: 4*(hdr_dw + data_dw + td), 13 bits wide so that
  // a 4DW header with 1024 DW payload and digest (4116 bytes) cannot wrap.
  function automatic logic [12:0] tlp_len_calc(input logic [31:0] dw0);
    logic [2:0]  hdr_dw;
    logic [10:0] data_dw;
    logic [10:0] sum_dw;
    hdr_dw = dw0[29] ? 3'd4 : 3'd3;
    if (dw0[30]) begin
      data_dw = (dw0[9:0] == 10'd0) ? 11'd1024 : {1'b0, dw0[9:0]};
    end else begin
      data_dw = 11'd0;
    end
    sum_dw = data_dw + {8'd0, hdr_dw} + {10'd0, dw0[15]};
    return {sum_dw, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/tlp_rx_capture_if.sv
`default_nettype none
// ============================================================================
//  Module   : tlp_rx_capture_if
//  Purpose  : Bundles the snooped PCIe RX AXI-Stream and the RX FIFO write
//             port. master = environment/stream side, slave = capture block.
//  Revision : 1.0  initial release
// ============================================================================
interface tlp_rx_capture_if;
  import pcie_tlp_pkg::*;

  logic                      rx_tvalid;
  logic                      rx_tready;
  logic                      rx_tlast;
  logic [7:0]                rx_tkeep;
  logic [63:0]               rx_tdata;
  logic [RX_USER-1:0]        rx_tuser;

  logic                      wr_en;
  logic [PCIE_FIFO64_RX-1:0] din;
  logic                      full;
  logic                      prog_full;

  modport master (
    output rx_tvalid, rx_tready, rx_tlast, rx_tkeep, rx_tdata, rx_tuser,
    output full, prog_full,
    input  wr_en, din
  );

  modport slave (
    input  rx_tvalid, rx_tready, rx_tlast, rx_tkeep, rx_tdata, rx_tuser,
    input  full, prog_full,
    output wr_en, din
  );

endinterface
`default_nettype wire

// File: rtl/tlp_hdr_decode.sv
`default_nettype none
// ============================================================================
//  Module   : tlp_hdr_decode
//  Purpose  : Combinational decode of the first TLP beat: type class, header
//             size, total byte length and the request tag from DW1.
//  Revision : 1.0  initial release
// ============================================================================
module tlp_hdr_decode
  import pcie_tlp_pkg::*;
(
  input  logic [31:0] dw0,
  input  logic [31:0] dw1,
  output logic        is_mem,
  output logic        is_cpl,
  output logic [2:0]  hdr_dw,
  output logic [12:0] tlp_len,
  output logic [7:0]  req_tag
);

  // Type class, header size, length and request tag straight from the header
  assign is_mem  = (dw0[28:25] == TYPE_MEM_HI);
  assign is_cpl  = (dw0[28:24] == TYPE_CPL);
  assign hdr_dw  = dw0[29] ? 3'd4 : 3'd3;
  assign tlp_len = tlp_len_calc(dw0);
  assign req_tag = dw1[15:8];

  // Header fields that play no part in sizing or tagging
  logic unused_hdr_bits;
  assign unused_hdr_bits = ^{dw0[31], dw0[23:16], dw0[14:10], dw1[31:16], dw1[7:0]};

endmodule
`default_nettype wire

// File: rtl/tlp_rx_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tlp_rx_capture
//  Purpose  : Snoops the 64-bit PCIe RX stream and copies every accepted TLP
//             into the RX FIFO, each word tagged with the TLP byte length and
//             tag. One beat is held back so the first word already carries
//             the completion tag found in beat 1. Never back-pressures.
//  Revision : 1.0  initial release
// ============================================================================
module tlp_rx_capture
  import pcie_tlp_pkg::*;
#(
  parameter int MAX_TLP_BYTES = 1024,
  parameter bit CAPTURE_MEM   = 1'b1,
  parameter bit CAPTURE_CPL   = 1'b1,
  parameter bit CAPTURE_OTHER = 1'b0
) (
  input  logic                   pcie_clk,
  input  logic                   pcie_rst,
  tlp_rx_capture_if.slave        bus,
  output logic [31:0]            cnt_capt,
  output logic [31:0]            cnt_drop,
  output logic                   err_ovf
);

  localparam logic [12:0] MAX_LEN = 13'(MAX_TLP_BYTES);

  // --------------------------------------------------------------------------
  // SOF header decode
  // --------------------------------------------------------------------------
  logic        is_mem;
  logic        is_cpl;
  logic [2:0]  hdr_dw;
  logic [12:0] tlp_len;
  logic [7:0]  req_tag;

  tlp_hdr_decode u_hdr_decode (
    .dw0     (bus.rx_tdata[31:0]),
    .dw1     (bus.rx_tdata[63:32]),
    .is_mem  (is_mem),
    .is_cpl  (is_cpl),
    .hdr_dw  (hdr_dw),
    .tlp_len (tlp_len),
    .req_tag (req_tag)
  );

  logic unused_hdr_dw;
  assign unused_hdr_dw = ^hdr_dw;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t      state_q,        state_d;
  hold_t       hold_q,         hold_d;
  fifo_word_t  din_q,          din_d;
  logic        wr_en_q,        wr_en_d;
  logic        in_pkt_q,       in_pkt_d;
  logic        cpl_tag_pend_q, cpl_tag_pend_d;  // next beat is completion beat 1
  logic        abort_q,        abort_d;         // rest of current TLP suppressed
  logic        err_ovf_q,      err_ovf_d;
  logic [31:0] cnt_capt_q,     cnt_capt_d;
  logic [31:0] cnt_drop_q,     cnt_drop_d;

  logic        beat;
  logic        sof;
  logic        type_en;
  logic        drop;
  logic        want_wr;
  hold_t       wr_word;
  logic [7:0]  body_tag;

  assign beat    = bus.rx_tvalid & bus.rx_tready;
  assign sof     = beat & ~in_pkt_q;
  assign type_en = is_mem ? CAPTURE_MEM : (is_cpl ? CAPTURE_CPL : CAPTURE_OTHER);
  // A single-beat TLP cannot hold a full header, so tlast on SOF is malformed
  assign drop    = bus.prog_full | ~type_en | (tlp_len > MAX_LEN) | bus.rx_tlast;

  // Next-state, hold register, write generation and counters
  always_comb begin
    state_d        = state_q;
    hold_d         = hold_q;
    din_d          = din_q;
    wr_en_d        = 1'b0;
    in_pkt_d       = in_pkt_q;
    cpl_tag_pend_d = cpl_tag_pend_q;
    abort_d        = abort_q;
    err_ovf_d      = err_ovf_q;
    cnt_capt_d     = cnt_capt_q;
    cnt_drop_d     = cnt_drop_q;
    want_wr        = 1'b0;
    wr_word        = hold_q;
    body_tag       = cpl_tag_pend_q ? bus.rx_tdata[15:8] : hold_q.tlp_tag;

    if (beat) begin
      in_pkt_d = ~bus.rx_tlast;
    end

    case (state_q)
      S_IDLE: begin
      end
      S_BODY: begin
        if (beat) begin
          // Emit the held beat; a completion learns its tag from this beat
          want_wr          = 1'b1;
          wr_word.tlp_tag  = body_tag;
          hold_d.tdata     = bus.rx_tdata;
          hold_d.tkeep     = bus.rx_tkeep;
          hold_d.tuser     = bus.rx_tuser;
          hold_d.last      = bus.rx_tlast;
          hold_d.tlp_tag   = body_tag;
          cpl_tag_pend_d   = 1'b0;
          if (bus.rx_tlast) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        want_wr = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A full FIFO kills this and every later write of the TLP
    if (want_wr) begin
      if (bus.full || abort_q) begin
        abort_d = 1'b1;
        if (bus.full) begin
          err_ovf_d = 1'b1;
        end
      end else begin
        wr_en_d       = 1'b1;
        din_d.tvalid  = 1'b1;
        din_d.tlast   = wr_word.last;
        din_d.tkeep   = wr_word.tkeep;
        din_d.tdata   = wr_word.tdata;
        din_d.tuser   = wr_word.tuser;
        din_d.tlp_len = wr_word.tlp_len;
        din_d.tlp_tag = wr_word.tlp_tag;
        if (state_q == S_FLUSH) begin
          cnt_capt_d = cnt_capt_q + 32'd1;
        end
      end
    end

    if (state_q == S_FLUSH) begin
      abort_d = 1'b0;
    end

    // SOF: either count a drop or load the first beat into the hold register
    if (sof) begin
      if (drop) begin
        cnt_drop_d = cnt_drop_q + 32'd1;
      end else begin
        hold_d.tdata   = bus.rx_tdata;
        hold_d.tkeep   = bus.rx_tkeep;
        hold_d.tuser   = bus.rx_tuser;
        hold_d.last    = 1'b0;
        hold_d.tlp_len = tlp_len[TLP_LEN-1:0];
        hold_d.tlp_tag = req_tag;
        cpl_tag_pend_d = is_cpl;
        abort_d        = 1'b0;
        state_d        = S_BODY;
      end
    end
  end

  // All state and registered outputs, asynchronously cleared
  always_ff @(posedge pcie_clk or posedge pcie_rst) begin
    if (pcie_rst) begin
      state_q        <= S_IDLE;
      hold_q         <= '0;
      din_q          <= '0;
      wr_en_q        <= 1'b0;
      in_pkt_q       <= 1'b0;
      cpl_tag_pend_q <= 1'b0;
      abort_q        <= 1'b0;
      err_ovf_q      <= 1'b0;
      cnt_capt_q     <= 32'd0;
      cnt_drop_q     <= 32'd0;
    end else begin
      state_q        <= state_d;
      hold_q         <= hold_d;
      din_q          <= din_d;
      wr_en_q        <= wr_en_d;
      in_pkt_q       <= in_pkt_d;
      cpl_tag_pend_q <= cpl_tag_pend_d;
      abort_q        <= abort_d;
      err_ovf_q      <= err_ovf_d;
      cnt_capt_q     <= cnt_capt_d;
      cnt_drop_q     <= cnt_drop_d;
    end
  end

  assign bus.wr_en = wr_en_q;
  assign bus.din   = din_q;
  assign cnt_capt  = cnt_capt_q;
  assign cnt_drop  = cnt_drop_q;
  assign err_ovf   = err_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_tlp_rx_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tlp_rx_capture
//  Purpose  : Directed self-checking bench for tlp_rx_capture.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tlp_rx_capture;

  logic        pcie_clk = 1'b0;
  logic        pcie_rst = 1'b0;
  logic [31:0] cnt_capt;
  logic [31:0] cnt_drop;
  logic        err_ovf;

  always #5 pcie_clk = ~pcie_clk;

  tlp_rx_capture_if bus ();

  tlp_rx_capture #(
    .MAX_TLP_BYTES (1024),
    .CAPTURE_MEM   (1'b1),
    .CAPTURE_CPL   (1'b1),
    .CAPTURE_OTHER (1'b0)
  ) dut (
    .pcie_clk (pcie_clk),
    .pcie_rst (pcie_rst),
    .bus      (bus.slave),
    .cnt_capt (cnt_capt),
    .cnt_drop (cnt_drop),
    .err_ovf  (err_ovf)
  );

  // FIFO-side monitor: collect every written word
  logic [114:0] wq[$];
  always @(negedge pcie_clk) begin
    if (bus.wr_en === 1'b1) wq.push_back(bus.din);
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [21:0] user_of(input logic [63:0] d);
    return {6'h15, d[15:0]};
  endfunction

  task automatic beat(input logic last, input logic [7:0] keep, input logic [63:0] data);
    bus.rx_tvalid = 1'b1;
    bus.rx_tready = 1'b1;
    bus.rx_tlast  = last;
    bus.rx_tkeep  = keep;
    bus.rx_tdata  = data;
    bus.rx_tuser  = user_of(data);
    @(posedge pcie_clk); #1;
  endtask

  task automatic idle(input int n);
    bus.rx_tvalid = 1'b0;
    bus.rx_tlast  = 1'b0;
    repeat (n) begin @(posedge pcie_clk); #1; end
  endtask

  // valid but not ready: not a beat
  task automatic stall(input int n);
    bus.rx_tvalid = 1'b1;
    bus.rx_tready = 1'b0;
    bus.rx_tdata  = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (n) begin @(posedge pcie_clk); #1; end
    bus.rx_tready = 1'b1;
  endtask

  task automatic pulse_rst();
    bus.rx_tvalid = 1'b0;
    pcie_rst = 1'b1;
    #1;
    chk("rst wr_en", {63'd0, bus.wr_en}, 64'd0);
    chk("rst din zero", {63'd0, |bus.din}, 64'd0);
    chk("rst cnt_capt", {32'd0, cnt_capt}, 64'd0);
    chk("rst cnt_drop", {32'd0, cnt_drop}, 64'd0);
    chk("rst err_ovf", {63'd0, err_ovf}, 64'd0);
    #1;
    pcie_rst = 1'b0;
    wq.delete();
  endtask

  task automatic pop_chk(input string tag, input logic [63:0] data, input logic [7:0] keep,
                         input logic last, input logic [10:0] len, input logic [7:0] ttag);
    logic [114:0] w;
    if (wq.size() == 0) begin
      chk({tag, " present"}, 64'd0, 64'd1);
      return;
    end
    w = wq.pop_front();
    chk({tag, " tvalid"}, {63'd0, w[114]}, 64'd1);
    chk({tag, " tlast"},  {63'd0, w[113]}, {63'd0, last});
    chk({tag, " tkeep"},  {56'd0, w[112:105]}, {56'd0, keep});
    chk({tag, " tdata"},  w[104:41], data);
    chk({tag, " tuser"},  {42'd0, w[40:19]}, {42'd0, user_of(data)});
    chk({tag, " tlp_len"}, {53'd0, w[18:8]}, {53'd0, len});
    chk({tag, " tlp_tag"}, {56'd0, w[7:0]}, {56'd0, ttag});
  endtask

  function automatic logic [63:0] long_data(input int i);
    if (i == 0) return {32'h0000_990F, 32'h6000_00FC};  // MWr 4DW len=252 tag 0x99
    return {32'hB000_0000 + 32'(i), 32'hA000_0000 + 32'(i)};
  endfunction

  initial begin
    bus.rx_tvalid = 1'b0;
    bus.rx_tready = 1'b1;
    bus.rx_tlast  = 1'b0;
    bus.rx_tkeep  = 8'h00;
    bus.rx_tdata  = 64'd0;
    bus.rx_tuser  = 22'd0;
    bus.full      = 1'b0;
    bus.prog_full = 1'b0;
    @(posedge pcie_clk); #1;

    // 1: MWr 3DW len=2 tag 0x5A, with a stall inside -> 3 words, 20 bytes
    pulse_rst();
    beat(1'b0, 8'hFF, {32'h0000_5A0F, 32'h4000_0002});
    stall(2);
    beat(1'b0, 8'hFF, {32'h1111_2222, 32'hA000_0000});
    beat(1'b1, 8'h0F, {32'hDEAD_BEEF, 32'h3333_4444});
    idle(3);
    chk("t1 count", 64'(wq.size()), 64'd3);
    pop_chk("t1 w0", {32'h0000_5A0F, 32'h4000_0002}, 8'hFF, 1'b0, 11'd20, 8'h5A);
    pop_chk("t1 w1", {32'h1111_2222, 32'hA000_0000}, 8'hFF, 1'b0, 11'd20, 8'h5A);
    pop_chk("t1 w2", {32'hDEAD_BEEF, 32'h3333_4444}, 8'h0F, 1'b1, 11'd20, 8'h5A);
    chk("t1 cnt_capt", {32'd0, cnt_capt}, 64'd1);

    // 2: CplD 3DW len=1, DW1[15:8]=0x33 (not the tag), DW2 tag 0x07
    beat(1'b0, 8'hFF, {32'h0000_3304, 32'h4A00_0001});
    beat(1'b1, 8'hFF, {32'hCAFE_F00D, 32'h0000_0700});
    idle(3);
    chk("t2 count", 64'(wq.size()), 64'd2);
    pop_chk("t2 w0", {32'h0000_3304, 32'h4A00_0001}, 8'hFF, 1'b0, 11'd16, 8'h07);
    pop_chk("t2 w1", {32'hCAFE_F00D, 32'h0000_0700}, 8'hFF, 1'b1, 11'd16, 8'h07);
    chk("t2 cnt_capt", {32'd0, cnt_capt}, 64'd2);

    // 3: CplD (tag 0x22) immediately followed by MRd 4DW (tag 0x11)
    pulse_rst();
    beat(1'b0, 8'hFF, {32'h0000_4404, 32'h4A00_0001});
    beat(1'b1, 8'hFF, {32'h1234_5678, 32'h0000_2200});
    beat(1'b0, 8'hFF, {32'h0000_110F, 32'h2000_0001});
    beat(1'b1, 8'hFF, {32'h89AB_CDE0, 32'h0000_0001});
    idle(3);
    chk("t3 count", 64'(wq.size()), 64'd4);
    pop_chk("t3 w0", {32'h0000_4404, 32'h4A00_0001}, 8'hFF, 1'b0, 11'd16, 8'h22);
    pop_chk("t3 w1", {32'h1234_5678, 32'h0000_2200}, 8'hFF, 1'b1, 11'd16, 8'h22);
    pop_chk("t3 w2", {32'h0000_110F, 32'h2000_0001}, 8'hFF, 1'b0, 11'd16, 8'h11);
    pop_chk("t3 w3", {32'h89AB_CDE0, 32'h0000_0001}, 8'hFF, 1'b1, 11'd16, 8'h11);
    chk("t3 cnt_capt", {32'd0, cnt_capt}, 64'd2);

    // 4: drops - prog_full, len=0 oversize, Cfg type, tlast on SOF, 1028 bytes
    pulse_rst();
    bus.prog_full = 1'b1;
    beat(1'b0, 8'hFF, {32'h0000_5A0F, 32'h4000_0004});
    bus.prog_full = 1'b0;
    beat(1'b0, 8'hFF, 64'h1);
    beat(1'b0, 8'hFF, 64'h2);
    beat(1'b1, 8'hFF, 64'h3);
    idle(2);
    chk("t4 pf count", 64'(wq.size()), 64'd0);
    chk("t4 pf cnt_drop", {32'd0, cnt_drop}, 64'd1);
    beat(1'b0, 8'hFF, {32'h0000_770F, 32'h4000_0000});
    beat(1'b0, 8'hFF, 64'h4);
    beat(1'b1, 8'hFF, 64'h5);
    idle(2);
    chk("t4 len0 cnt_drop", {32'd0, cnt_drop}, 64'd2);
    beat(1'b0, 8'hFF, {32'h0000_200F, 32'h0400_0001});
    beat(1'b1, 8'h0F, 64'h6);
    beat(1'b1, 8'hFF, {32'h0000_010F, 32'h4000_0001});
    beat(1'b0, 8'hFF, {32'h0000_010F, 32'h6000_00FD});
    beat(1'b1, 8'hFF, 64'h7);
    idle(2);
    chk("t4 all count", 64'(wq.size()), 64'd0);
    chk("t4 all cnt_drop", {32'd0, cnt_drop}, 64'd5);
    chk("t4 cnt_capt", {32'd0, cnt_capt}, 64'd0);
    // exactly MAX_TLP_BYTES: 4DW len=252 -> 1024 bytes, 128 beats
    for (int i = 0; i < 128; i++) beat(i == 127, 8'hFF, long_data(i));
    idle(3);
    chk("t4 max count", 64'(wq.size()), 64'd128);
    for (int i = 0; i < 128; i++) pop_chk("t4 max w", long_data(i), 8'hFF, i == 127, 11'd1024, 8'h99);
    chk("t4 max cnt_capt", {32'd0, cnt_capt}, 64'd1);

    // 5: full on the 2nd write of a 4-beat MWr, then a clean TLP
    pulse_rst();
    beat(1'b0, 8'hFF, {32'h0000_3C0F, 32'h4000_0004});
    beat(1'b0, 8'hFF, 64'h10);
    bus.full = 1'b1;
    beat(1'b0, 8'hFF, 64'h11);
    beat(1'b1, 8'hFF, 64'h12);
    bus.full = 1'b0;
    idle(3);
    chk("t5 count", 64'(wq.size()), 64'd1);
    pop_chk("t5 w0", {32'h0000_3C0F, 32'h4000_0004}, 8'hFF, 1'b0, 11'd28, 8'h3C);
    chk("t5 err_ovf", {63'd0, err_ovf}, 64'd1);
    beat(1'b0, 8'hFF, {32'h0000_5A0F, 32'h4000_0002});
    beat(1'b0, 8'hFF, {32'h1111_2222, 32'hA000_0000});
    beat(1'b1, 8'h0F, {32'hDEAD_BEEF, 32'h3333_4444});
    idle(3);
    chk("t5 next count", 64'(wq.size()), 64'd3);
    pop_chk("t5n w0", {32'h0000_5A0F, 32'h4000_0002}, 8'hFF, 1'b0, 11'd20, 8'h5A);
    pop_chk("t5n w1", {32'h1111_2222, 32'hA000_0000}, 8'hFF, 1'b0, 11'd20, 8'h5A);
    pop_chk("t5n w2", {32'hDEAD_BEEF, 32'h3333_4444}, 8'h0F, 1'b1, 11'd20, 8'h5A);
    chk("t5 err_ovf sticky", {63'd0, err_ovf}, 64'd1);

    // 6: async reset mid-TLP while a write is on the output
    beat(1'b0, 8'hFF, {32'h0000_3C0F, 32'h4000_0004});
    beat(1'b0, 8'hFF, 64'h20);
    chk("t6 wr_en before", {63'd0, bus.wr_en}, 64'd1);
    pulse_rst();
    beat(1'b0, 8'hFF, {32'h0000_5A0F, 32'h4000_0002});
    beat(1'b0, 8'hFF, {32'h1111_2222, 32'hA000_0000});
    beat(1'b1, 8'h0F, {32'hDEAD_BEEF, 32'h3333_4444});
    idle(3);
    chk("t6 count", 64'(wq.size()), 64'd3);
    pop_chk("t6 w0", {32'h0000_5A0F, 32'h4000_0002}, 8'hFF, 1'b0, 11'd20, 8'h5A);
    pop_chk("t6 w1", {32'h1111_2222, 32'hA000_0000}, 8'hFF, 1'b0, 11'd20, 8'h5A);
    pop_chk("t6 w2", {32'hDEAD_BEEF, 32'h3333_4444}, 8'h0F, 1'b1, 11'd20, 8'h5A);
    chk("t6 cnt_capt", {32'd0, cnt_capt}, 64'd1);
    chk("t6 cnt_drop", {32'd0, cnt_drop}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
